// File: rtl/hazard_fwd_ctrl.sv
// Decode-side hazard/forwarding controller: per-source operand resolution against
// NFWD in-flight producers, load-use stall, redirect flush sequencing and a stall counter.

module hazard_fwd_src #(
    parameter int XLEN  = 32,
    parameter int REGAW = 5,
    parameter int NFWD  = 3
) (
    input  logic [REGAW-1:0]      src,
    input  logic                  use_src,
    input  logic [XLEN-1:0]       rdata,
    input  logic [NFWD-1:0]       prod_valid,
    input  logic [NFWD-1:0]       prod_wen,
    input  logic [NFWD-1:0]       prod_ready,
    input  logic [NFWD*REGAW-1:0] prod_rd,
    input  logic [NFWD*XLEN-1:0]  prod_data,
    output logic [XLEN-1:0]       opnd,
    output logic                  fwd,
    output logic                  pend
);
    // Walk oldest to youngest so the youngest match is the last one written.
    always_comb begin
        opnd = rdata;
        fwd  = 1'b0;
        pend = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (prod_valid[i] && prod_wen[i] && use_src && (src != '0) &&
                (prod_rd[i*REGAW +: REGAW] == src)) begin
                fwd  = prod_ready[i];
                pend = !prod_ready[i];
                opnd = prod_ready[i] ? prod_data[i*XLEN +: XLEN] : rdata;
            end
        end
    end
endmodule

module hazard_fwd_ctrl #(
    parameter int XLEN      = 32,
    parameter int REGAW     = 5,
    parameter int NFWD      = 3,
    parameter int FLUSH_CYC = 2,
    parameter int CNTW      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid,
    input  logic [REGAW-1:0]      dec_rs1,
    input  logic [REGAW-1:0]      dec_rs2,
    input  logic                  dec_use_rs1,
    input  logic                  dec_use_rs2,
    input  logic [XLEN-1:0]       dec_rdata_a,
    input  logic [XLEN-1:0]       dec_rdata_b,
    input  logic [NFWD-1:0]       prod_valid,
    input  logic [NFWD-1:0]       prod_wen,
    input  logic [NFWD*REGAW-1:0] prod_rd,
    input  logic [NFWD-1:0]       prod_ready,
    input  logic [NFWD*XLEN-1:0]  prod_data,
    input  logic                  redirect,
    output logic [XLEN-1:0]       opnd_a,
    output logic [XLEN-1:0]       opnd_b,
    output logic                  fwd_a,
    output logic                  fwd_b,
    output logic                  stall,
    output logic                  flush,
    output logic [CNTW-1:0]       stall_cnt
);
    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [3:0] RELOAD = 4'(FLUSH_CYC - 1);

    logic [1:0][REGAW-1:0] src;
    logic [1:0]            use_src;
    logic [1:0][XLEN-1:0]  rdata;
    logic [1:0][XLEN-1:0]  opnd;
    logic [1:0]            fwd;
    logic [1:0]            pend;

    state_t     state;
    logic [3:0] flush_cnt;

    assign src     = {dec_rs2, dec_rs1};
    assign use_src = {dec_use_rs2, dec_use_rs1};
    assign rdata   = {dec_rdata_b, dec_rdata_a};

    for (genvar s = 0; s < 2; s++) begin : g_src
        hazard_fwd_src #(.XLEN(XLEN), .REGAW(REGAW), .NFWD(NFWD)) u_src (
            .src        (src[s]),
            .use_src    (use_src[s]),
            .rdata      (rdata[s]),
            .prod_valid (prod_valid),
            .prod_wen   (prod_wen),
            .prod_ready (prod_ready),
            .prod_rd    (prod_rd),
            .prod_data  (prod_data),
            .opnd       (opnd[s]),
            .fwd        (fwd[s]),
            .pend       (pend[s])
        );
    end

    assign opnd_a = opnd[0];
    assign opnd_b = opnd[1];
    assign fwd_a  = fwd[0];
    assign fwd_b  = fwd[1];

    // The redirect cycle itself flushes combinationally; FLUSH covers the tail.
    assign flush = redirect | (state == FLUSH);
    assign stall = !rst & dec_valid & (|pend) & !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= 4'd0;
        end else if (redirect) begin
            state     <= (RELOAD == 4'd0) ? IDLE : FLUSH;
            flush_cnt <= RELOAD;
        end else if (state == FLUSH) begin
            if (flush_cnt <= 4'd1) begin
                state     <= IDLE;
                flush_cnt <= 4'd0;
            end else begin
                flush_cnt <= flush_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNTW'(1);
    end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: expected outputs are queued as stimulus is
// driven and popped/compared mid-cycle; stall_cnt is tracked by a saturating model.

module tb_hazard_fwd_ctrl;
    localparam int XLEN = 32, REGAW = 5, NFWD = 3, FLUSH_CYC = 2, CNTW = 4;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            fa;
        logic            fb;
        logic            st;
        logic            fl;
    } out_t;

    logic clk = 1'b0;
    logic rst;
    logic dec_valid, dec_use_rs1, dec_use_rs2, redirect;
    logic [REGAW-1:0] dec_rs1, dec_rs2;
    logic [XLEN-1:0] dec_rdata_a, dec_rdata_b;
    logic [NFWD-1:0] prod_valid, prod_wen, prod_ready;
    logic [NFWD*REGAW-1:0] prod_rd;
    logic [NFWD*XLEN-1:0] prod_data;
    logic [XLEN-1:0] opnd_a, opnd_b;
    logic fwd_a, fwd_b, stall, flush;
    logic [CNTW-1:0] stall_cnt;

    out_t obs, e;
    out_t sb[$];
    int total = 0, bad = 0, exp_cnt = 0;

    hazard_fwd_ctrl #(.XLEN(XLEN), .REGAW(REGAW), .NFWD(NFWD),
                      .FLUSH_CYC(FLUSH_CYC), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .dec_rdata_a(dec_rdata_a), .dec_rdata_b(dec_rdata_b),
        .prod_valid(prod_valid), .prod_wen(prod_wen), .prod_rd(prod_rd),
        .prod_ready(prod_ready), .prod_data(prod_data), .redirect(redirect),
        .opnd_a(opnd_a), .opnd_b(opnd_b), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall(stall), .flush(flush), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {opnd_a, opnd_b, fwd_a, fwd_b, stall, flush};

    function automatic out_t mk(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                input logic fa, input logic fb, input logic st, input logic fl);
        return {a, b, fa, fb, st, fl};
    endfunction

    task automatic clear_in();
        dec_valid = 0; dec_use_rs1 = 0; dec_use_rs2 = 0; redirect = 0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rdata_a = '0; dec_rdata_b = '0;
        prod_valid = '0; prod_wen = '0; prod_ready = '0; prod_rd = '0; prod_data = '0;
    endtask

    task automatic set_prod(input int i, input logic v, input logic w, input logic [REGAW-1:0] rd,
                            input logic rdy, input logic [XLEN-1:0] d);
        prod_valid[i] = v; prod_wen[i] = w; prod_ready[i] = rdy;
        prod_rd[i*REGAW +: REGAW] = rd;
        prod_data[i*XLEN +: XLEN] = d;
    endtask

    // Advance one clock; the model counts the edge if a stall was expected in that cycle.
    task automatic tick(input logic st_exp);
        @(posedge clk);
        if (st_exp && exp_cnt < 15) exp_cnt++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1; clear_in();
        set_prod(0, 1, 1, 5'd7, 0, 32'h99);
        dec_rs2 = 5'd7; dec_use_rs2 = 1; dec_valid = 1; dec_rdata_b = 32'h55;
        sb.push_back(mk(0, 32'h55, 0, 0, 0, 0));
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL reset_outs got=%h exp=%h", obs, e); end
        total++;
        if (stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        redirect = 1;
        sb.push_back(mk(0, 32'h55, 0, 0, 0, 1));
        #2;
        e = sb.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL reset_redirect got=%h exp=%h", obs, e); end
        clear_in();
        @(posedge clk); #1;
        rst = 0; exp_cnt = 0;
    endtask

    task automatic test_no_hazard();
        clear_in();
        dec_valid = 1; dec_rs1 = 5'd5; dec_rs2 = 5'd6; dec_use_rs1 = 1; dec_use_rs2 = 1;
        dec_rdata_a = 32'h11; dec_rdata_b = 32'h22;
        set_prod(0, 1, 1, 5'd9, 1, 32'h99);
        set_prod(1, 1, 0, 5'd5, 1, 32'h77);
        set_prod(2, 0, 1, 5'd6, 1, 32'h66);
        sb.push_back(mk(32'h11, 32'h22, 0, 0, 0, 0));
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL no_hazard got=%h exp=%h", obs, e); end
        tick(0);
    endtask

    task automatic test_priority();
        clear_in();
        dec_valid = 1; dec_rs1 = 5'd5; dec_rs2 = 5'd6; dec_use_rs1 = 1; dec_use_rs2 = 1;
        dec_rdata_a = 32'h11; dec_rdata_b = 32'h22;
        set_prod(0, 1, 1, 5'd5, 1, 32'hAAAA);
        set_prod(1, 1, 1, 5'd6, 1, 32'hCCCC);
        set_prod(2, 1, 1, 5'd5, 1, 32'hBBBB);
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: sb.push_back(mk(32'hAAAA, 32'hCCCC, 1, 1, 0, 0));
                1: begin prod_valid[0] = 0; sb.push_back(mk(32'hBBBB, 32'hCCCC, 1, 1, 0, 0)); end
                2: begin
                    // Youngest match not ready hides a ready older one.
                    dec_valid = 0; set_prod(0, 1, 1, 5'd5, 0, 32'hAAAA);
                    sb.push_back(mk(32'h11, 32'hCCCC, 0, 1, 0, 0));
                end
                default: begin
                    dec_use_rs1 = 0; dec_valid = 1; prod_ready[0] = 1;
                    sb.push_back(mk(32'h11, 32'hCCCC, 0, 1, 0, 0));
                end
            endcase
            @(negedge clk);
            e = sb.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL priority_%0d got=%h exp=%h", k, obs, e); end
            tick(0);
        end
    endtask

    task automatic test_load_use();
        rst = 1; #2; rst = 0; exp_cnt = 0;
        clear_in();
        dec_valid = 1; dec_rs2 = 5'd7; dec_use_rs2 = 1; dec_rdata_b = 32'h22;
        set_prod(0, 1, 1, 5'd7, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk(0, 32'h22, 0, 0, 1, 0));
            @(negedge clk);
            e = sb.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL load_use_%0d got=%h exp=%h", k, obs, e); end
            tick(1);
            total++;
            if (stall_cnt !== 4'(exp_cnt)) begin
                bad++; $display("FAIL load_use_cnt_%0d got=%0d exp=%0d", k, stall_cnt, exp_cnt);
            end
        end
        set_prod(0, 1, 1, 5'd7, 1, 32'h1234);
        sb.push_back(mk(0, 32'h1234, 0, 1, 0, 0));
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL load_use_ready got=%h exp=%h", obs, e); end
        tick(0);
        total++;
        if (stall_cnt !== 4'd3) begin bad++; $display("FAIL load_use_hold got=%0d exp=3", stall_cnt); end
    endtask

    task automatic test_x0();
        clear_in();
        dec_valid = 1; dec_use_rs1 = 1; dec_use_rs2 = 1; dec_rdata_b = 32'h33;
        set_prod(0, 1, 1, 5'd0, 1, 32'hFFFF);
        set_prod(1, 1, 1, 5'd0, 0, 32'hEEEE);
        sb.push_back(mk(0, 32'h33, 0, 0, 0, 0));
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL x0_guard got=%h exp=%h", obs, e); end
        tick(0);
    endtask

    task automatic test_redirect();
        logic rd_tab [8] = '{0, 1, 0, 0, 1, 1, 0, 0};
        logic fl_tab [8] = '{0, 1, 1, 0, 1, 1, 1, 0};
        rst = 1; #2; rst = 0; exp_cnt = 0;
        clear_in();
        dec_valid = 1; dec_rs2 = 5'd7; dec_use_rs2 = 1; dec_rdata_b = 32'h22;
        set_prod(0, 1, 1, 5'd7, 0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            redirect = rd_tab[k];
            sb.push_back(mk(0, 32'h22, 0, 0, !fl_tab[k], fl_tab[k]));
            @(negedge clk);
            e = sb.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL redirect_%0d got=%h exp=%h", k, obs, e); end
            tick(!fl_tab[k]);
            total++;
            if (stall_cnt !== 4'(exp_cnt)) begin
                bad++; $display("FAIL redirect_cnt_%0d got=%0d exp=%0d", k, stall_cnt, exp_cnt);
            end
        end
        redirect = 0;
    endtask

    task automatic test_reset_midflush();
        redirect = 1;
        tick(0);
        redirect = 0; rst = 1;
        sb.push_back(mk(0, 32'h22, 0, 0, 0, 0));
        #1;
        e = sb.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL midflush_rst got=%h exp=%h", obs, e); end
        total++;
        if (stall_cnt !== 4'd0) begin bad++; $display("FAIL midflush_cnt got=%0d exp=0", stall_cnt); end
        exp_cnt = 0;
        @(posedge clk); #1;
        rst = 0;
        sb.push_back(mk(0, 32'h22, 0, 0, 1, 0));
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL midflush_after got=%h exp=%h", obs, e); end
        tick(1);
    endtask

    task automatic test_saturation();
        rst = 1; #2; rst = 0; exp_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            sb.push_back(mk(0, 32'h22, 0, 0, 1, 0));
            @(negedge clk);
            e = sb.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL sat_outs_%0d got=%h exp=%h", k, obs, e); end
            tick(1);
            total++;
            if (stall_cnt !== 4'(exp_cnt)) begin
                bad++; $display("FAIL sat_cnt_%0d got=%0d exp=%0d", k, stall_cnt, exp_cnt);
            end
        end
        total++;
        if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_final got=%0d exp=15", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_priority();
        test_load_use();
        test_x0();
        test_redirect();
        test_reset_midflush();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Parametrised hazard, forwarding and redirect controller for the rv32 pipeline.
- Sits beside decode. Compares decode source registers against NFWD in-flight producer stages (index 0 = youngest, i.e. execute) and selects forwarded operands.
- Raises a load-use / not-ready stall when a required producer cannot supply data yet.
- Sequences a multi-cycle flush after a resolved control-flow redirect, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- XLEN, 32, datapath width.
- REGAW, 5, register index width.
- NFWD, 3, number of producer stages checked, 1..8.
- FLUSH_CYC, 2, number of cycles flush stays asserted after a redirect, 1..15.
- CNTW, 16, stall-counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- dec_valid  in  1  decode slot holds a real instruction.
- dec_rs1  in  REGAW  source register A index.
- dec_rs2  in  REGAW  source register B index.
- dec_use_rs1  in  1  instruction reads rs1.
- dec_use_rs2  in  1  instruction reads rs2.
- dec_rdata_a  in  XLEN  register-file read data A.
- dec_rdata_b  in  XLEN  register-file read data B.
- prod_valid  in  NFWD  stage i holds a real instruction.
- prod_wen  in  NFWD  stage i writes rd.
- prod_rd  in  NFWD*REGAW  rd of stage i, slice [i*REGAW +: REGAW].
- prod_ready  in  NFWD  stage i result is valid this cycle (0 for a load still in execute).
- prod_data  in  NFWD*XLEN  result of stage i, slice [i*XLEN +: XLEN].
- redirect  in  1  taken branch/jump resolved this cycle.
- opnd_a  out  XLEN  resolved operand A.
- opnd_b  out  XLEN  resolved operand B.
- fwd_a  out  1  operand A came from a producer.
- fwd_b  out  1  operand B came from a producer.
- stall  out  1  hold fetch/decode, inject bubble into execute.
- flush  out  1  kill fetch and decode contents.
- stall_cnt  out  CNTW  saturating count of stall cycles.

Behaviour:
- Match rule: stage i matches source s when prod_valid[i] & prod_wen[i] & prod_rd[i]==s & s!=0 & dec_use_s.
- Register x0 never matches; its operand is always dec_rdata.
- Priority: the lowest-index (youngest) matching stage wins. Older matches are ignored even if ready.
- If the winning stage has prod_ready=1: operand = prod_data[i] and fwd_x=1. Otherwise operand = dec_rdata_x and fwd_x=0.
- Operand selection is combinational, with zero-cycle latency.
- Stall condition: dec_valid & (winning match on A or B has prod_ready=0) & !flush.
- stall is combinational from the inputs plus the FSM state.
- Flush FSM has two states, IDLE and FLUSH, with a 4-bit down-counter.
- IDLE: redirect=1 → FLUSH, counter loaded with FLUSH_CYC-1.
- FLUSH: flush=1. Counter decrements each cycle; at 0 → IDLE.
- redirect while in FLUSH reloads the counter to FLUSH_CYC-1 (restart).
- flush output: asserted combinationally in the redirect cycle, then registered for the remaining FLUSH_CYC-1 cycles. Total assertion = FLUSH_CYC cycles per isolated redirect.
- Flush beats stall: stall=0 whenever flush=1.
- stall_cnt increments on every clock edge where stall=1. It saturates at all-ones and never wraps.
- Reset (async, at any point including mid-flush):
  - FSM → IDLE, counter=0, stall_cnt=0.
  - flush=0 unless redirect is high.
  - Combinational outputs follow their inputs during reset, except that stall is forced to 0.
- Multiple simultaneous matches on both A and B are resolved independently per source.

Test Plan:
- No hazard: rs1=5, rs2=6, no producer writing 5/6, rdata_a=0x11, rdata_b=0x22 → opnd_a=0x11, opnd_b=0x22, fwd=0, stall=0.
- Priority: stage0 rd=5 data=0xAAAA ready, stage2 rd=5 data=0xBBBB ready, rs1=5 → opnd_a=0xAAAA, fwd_a=1; drop stage0 valid → opnd_a=0xBBBB.
- Load-use: stage0 rd=7 ready=0, rs2=7, dec_valid=1 → stall=1 and stall_cnt +1 per cycle for 3 cycles (=3); set ready=1, data=0x1234 → stall=0, opnd_b=0x1234.
- x0 guard: stage0 rd=0 wen=1 data=0xFFFF, rs1=0, rdata_a=0 → opnd_a=0, fwd_a=0, stall=0.
- Redirect: FLUSH_CYC=2, single redirect pulse → flush=1 for exactly 2 cycles. A second redirect in cycle 2 → flush extends to 3 cycles total. A load-use stall concurrent with flush → stall=0.
- Reset mid-flush / saturation: assert rst during FLUSH → flush=0 immediately, stall_cnt=0. With CNTW=4, hold stall for 20 cycles → stall_cnt=15.
